// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: centisecond stopwatch/countdown timer driving a six-digit seven-segment scanner
module stopwatch_ctrl #(
    parameter int         TICK_DIV   = 500000,
    parameter int         BLINK_DIV  = 12500000,
    parameter int         MAX_VAL    = 999999,
    parameter logic [5:0] POINT_MASK = 6'b000100
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        clear,
    input  logic        load,
    input  logic [19:0] preset,
    input  logic        dir,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        en,
    output logic        sign,
    output logic        sat
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [19:0]   MAX        = 20'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] blink, blink_n;
    logic [19:0]   data_n;
    logic          sign_n, sat_n, en_n, tick;

    // state and all registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            presc <= '0;
            blink <= '0;
            data  <= '0;
            sign  <= 1'b0;
            sat   <= 1'b0;
            en    <= 1'b1;
            point <= POINT_MASK;
        end else begin
            state <= state_n;
            presc <= presc_n;
            blink <= blink_n;
            data  <= data_n;
            sign  <= sign_n;
            sat   <= sat_n;
            en    <= en_n;
            point <= POINT_MASK;
        end
    end

    // next state: tick count update, then start, then load, then clear (highest priority last)
    always_comb begin
        state_n = state;
        presc_n = presc;
        blink_n = '0;
        data_n  = data;
        sign_n  = sign;
        sat_n   = sat;
        en_n    = 1'b1;
        tick    = (state == RUN) && (presc == TICK_LAST);
        if (state == RUN)
            presc_n = tick ? '0 : presc + 1'b1;
        if (tick) begin
            if (dir == sign) begin
                if (data == MAX) begin
                    state_n = SAT;
                    sat_n   = 1'b1;
                end else begin
                    data_n = data + 20'd1;
                end
            end else if (data == '0) begin
                data_n = 20'd1;
                sign_n = 1'b1;
            end else begin
                data_n = data - 20'd1;
                sign_n = (data == 20'd1) ? 1'b0 : sign;
            end
        end
        if (start && state_n != SAT)
            state_n = (state == RUN) ? PAUSE : RUN;
        if (state == PAUSE && state_n == PAUSE) begin
            blink_n = (blink == BLINK_LAST) ? '0 : blink + 1'b1;
            en_n    = (blink == BLINK_LAST) ? ~en : en;
        end
        if (load) begin
            state_n = IDLE;
            presc_n = '0;
            blink_n = '0;
            data_n  = (preset > MAX) ? MAX : preset;
            sign_n  = 1'b0;
            sat_n   = 1'b0;
            en_n    = 1'b1;
        end
        if (clear) begin
            state_n = IDLE;
            presc_n = '0;
            blink_n = '0;
            data_n  = '0;
            sign_n  = 1'b0;
            sat_n   = 1'b0;
            en_n    = 1'b1;
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl with short dividers
module tb_stopwatch_ctrl;
    logic        sys_clk, sys_rst, start, clear, load, dir;
    logic [19:0] preset, data;
    logic [5:0]  point;
    logic        en, sign, sat;

    typedef struct packed {
        logic [19:0] d;
        logic        s;
        logic        e;
        logic        t;
        logic [5:0]  p;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    n_chk = 0;
    int    n_fail = 0;

    stopwatch_ctrl #(
        .TICK_DIV(4),
        .BLINK_DIV(8),
        .MAX_VAL(999999),
        .POINT_MASK(6'b000100)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .start(start),
        .clear(clear),
        .load(load),
        .preset(preset),
        .dir(dir),
        .data(data),
        .point(point),
        .en(en),
        .sign(sign),
        .sat(sat)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push(input string tag, input logic [19:0] d, input logic s, input logic e, input logic t);
        exp_t x;
        x = '{d: d, s: s, e: e, t: t, p: 6'b000100};
        q.push_back(x);
        tq.push_back(tag);
    endtask

    task automatic check_front();
        exp_t  x, a;
        string tag;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed empty queue, expected an entry");
            return;
        end
        x   = q.pop_front();
        tag = tq.pop_front();
        a   = {data, sign, en, sat, point};
        assert (a === x) else begin
            n_fail++;
            $error("FAIL %s: observed data=%0d sign=%b en=%b sat=%b point=%b, expected data=%0d sign=%b en=%b sat=%b point=%b",
                   tag, a.d, a.s, a.e, a.t, a.p, x.d, x.s, x.e, x.t, x.p);
        end
    endtask

    task automatic exp_now(input string tag, input logic [19:0] d, input logic s, input logic e, input logic t);
        push(tag, d, s, e, t);
        check_front();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [19:0] v);
        preset = v;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        preset = '0;
        dir = 1'b0;
        cyc(2);
        exp_now("reset", 0, 0, 1, 0);
        sys_rst = 1'b0;
        cyc(1);
        // count up: first increment 5 cycles after start, 10 after 40 cycles
        pulse_start();
        cyc(3);
        exp_now("before_first_tick", 0, 0, 1, 0);
        cyc(1);
        exp_now("first_tick", 1, 0, 1, 0);
        cyc(36);
        exp_now("run40", 10, 0, 1, 0);
        // pause with two prescaler counts pending, blink, resume
        cyc(2);
        pulse_start();
        exp_now("pause_frozen", 10, 0, 1, 0);
        cyc(7);
        exp_now("blink_still_on", 10, 0, 1, 0);
        cyc(1);
        exp_now("blink_low", 10, 0, 0, 0);
        cyc(8);
        exp_now("blink_high", 10, 0, 1, 0);
        pulse_start();
        exp_now("resume_en", 10, 0, 1, 0);
        cyc(1);
        exp_now("resume_tick", 11, 0, 1, 0);
        pulse_clear();
        exp_now("clear_run", 0, 0, 1, 0);
        // countdown through zero into overtime, then back up to zero
        dir = 1'b1;
        pulse_load(3);
        exp_now("load3", 3, 0, 1, 0);
        pulse_start();
        push("down_2", 2, 0, 1, 0);
        push("down_1", 1, 0, 1, 0);
        push("down_0", 0, 0, 1, 0);
        push("over_1", 1, 1, 1, 0);
        push("over_2", 2, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(4);
            check_front();
        end
        dir = 1'b0;
        push("back_1", 1, 1, 1, 0);
        push("back_0", 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(4);
            check_front();
        end
        pulse_clear();
        exp_now("clear_down", 0, 0, 1, 0);
        // saturation
        pulse_load(999998);
        pulse_start();
        cyc(4);
        exp_now("reach_max", 999999, 0, 1, 0);
        cyc(4);
        exp_now("saturate", 999999, 0, 1, 1);
        pulse_start();
        cyc(8);
        exp_now("sat_ignores_start", 999999, 0, 1, 1);
        pulse_clear();
        exp_now("clear_sat", 0, 0, 1, 0);
        cyc(8);
        exp_now("idle_after_clear", 0, 0, 1, 0);
        // clamp and priorities
        pulse_load(20'hFFFFF);
        exp_now("load_clamp", 999999, 0, 1, 0);
        preset = 5;
        clear = 1'b1;
        load = 1'b1;
        cyc(1);
        clear = 1'b0;
        load = 1'b0;
        exp_now("clear_beats_load", 0, 0, 1, 0);
        preset = 7;
        load = 1'b1;
        start = 1'b1;
        cyc(1);
        load = 1'b0;
        start = 1'b0;
        exp_now("load_beats_start", 7, 0, 1, 0);
        cyc(8);
        exp_now("load_stays_idle", 7, 0, 1, 0);
        // asynchronous reset mid-run
        pulse_start();
        cyc(9);
        exp_now("run_before_reset", 9, 0, 1, 0);
        #2 sys_rst = 1'b1;
        #1 exp_now("async_reset", 0, 0, 1, 0);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        cyc(12);
        exp_now("no_count_after_reset", 0, 0, 1, 0);
        pulse_start();
        cyc(4);
        exp_now("restart", 1, 0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
